// File: rtl/axi_sram_if.sv
// rtl/axi_sram_if.sv - AXI4-style *2 bus between a memory master and the SRAM slave
// Channels: AR (araddr2/arvalid2/arburst2/arlen2/arsize2/arready2),
//           R  (rdata2/rresp2/rvalid2/rlast2/rready2),
//           AW (awaddr2/awvalid2/awburst2/awlen2/awready2),
//           W  (wdata2/wlast2/wstrb2/wvalid2/wready2),
//           B  (bresp2/bvalid2/bready2).
interface axi_sram_if;
    logic [31:0] araddr2;
    logic        arvalid2;
    logic [1:0]  arburst2;
    logic [7:0]  arlen2;
    logic [2:0]  arsize2;
    logic        arready2;
    logic [63:0] rdata2;
    logic [1:0]  rresp2;
    logic        rvalid2;
    logic        rlast2;
    logic        rready2;
    logic [31:0] awaddr2;
    logic        awvalid2;
    logic [1:0]  awburst2;
    logic [7:0]  awlen2;
    logic        awready2;
    logic [63:0] wdata2;
    logic        wlast2;
    logic [7:0]  wstrb2;
    logic        wvalid2;
    logic        wready2;
    logic [1:0]  bresp2;
    logic        bvalid2;
    logic        bready2;

    modport slave (
        input  araddr2, arvalid2, arburst2, arlen2, arsize2, rready2,
        input  awaddr2, awvalid2, awburst2, awlen2,
        input  wdata2, wlast2, wstrb2, wvalid2, bready2,
        output arready2, rdata2, rresp2, rvalid2, rlast2,
        output awready2, wready2, bresp2, bvalid2
    );

    modport master (
        output araddr2, arvalid2, arburst2, arlen2, arsize2, rready2,
        output awaddr2, awvalid2, awburst2, awlen2,
        output wdata2, wlast2, wstrb2, wvalid2, bready2,
        input  arready2, rdata2, rresp2, rvalid2, rlast2,
        input  awready2, wready2, bresp2, bvalid2
    );
endinterface

// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - AXI4-style SRAM responder serving FIXED/INCR read and write bursts
// Ports: clk  - clock
//        rst  - synchronous reset, active low
//        bus  - axi_sram_if.slave; independent read (AR/R) and write (AW/W/B) channels
// Every bus output is a register; read and write FSMs run concurrently.
module axi_sram_slave #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int unsigned RD_WAIT    = 2
) (
    input  logic       clk,
    input  logic       rst,
    axi_sram_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    typedef logic [DEPTH_LOG2-1:0] idx_t;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    logic [63:0] mem [DEPTH];

    function automatic logic in_range(input logic [31:0] a);
        return (a >= BASE_ADDR) && (((a - BASE_ADDR) >> (DEPTH_LOG2 + 3)) == 32'd0);
    endfunction

    function automatic idx_t to_idx(input logic [31:0] a);
        return idx_t'((a - BASE_ADDR) >> 3);
    endfunction

    // FIXED repeats the start address; INCR steps one doubleword per beat.
    function automatic logic [31:0] step_addr(input logic [31:0] a, input logic [1:0] burst);
        return (burst == 2'b01) ? a + 32'd8 : a;
    endfunction

    // Read channel state
    r_state_t    r_state_q, r_state_d;
    logic [31:0] raddr_q, raddr_d;
    logic [7:0]  rlen_q, rlen_d, rbeat_q, rbeat_d;
    logic [1:0]  rburst_q, rburst_d;
    logic [3:0]  rwait_q, rwait_d;
    logic        arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [63:0] rdata_q, rdata_d;

    // Write channel state
    w_state_t    w_state_q, w_state_d;
    logic [31:0] waddr_q, waddr_d;
    logic [7:0]  wlen_q, wlen_d, wbeat_q, wbeat_d;
    logic [1:0]  wburst_q, wburst_d;
    logic        werr_dec_q, werr_dec_d, werr_slv_q, werr_slv_d;
    logic        awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        mem_we;

    // Beat to load into the R output registers this cycle, if any.
    logic        pres;
    logic [31:0] pres_addr;
    logic [1:0]  pres_burst;
    logic        pres_last;

    always_comb begin
        r_state_d  = r_state_q;
        raddr_d    = raddr_q;
        rlen_d     = rlen_q;
        rbeat_d    = rbeat_q;
        rburst_d   = rburst_q;
        rwait_d    = rwait_q;
        arready_d  = arready_q;
        rvalid_d   = rvalid_q;
        rlast_d    = rlast_q;
        rresp_d    = rresp_q;
        rdata_d    = rdata_q;
        pres       = 1'b0;
        pres_addr  = raddr_q;
        pres_burst = rburst_q;
        pres_last  = (rlen_q == 8'd0);
        unique case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (bus.arvalid2 && arready_q) begin
                    arready_d = 1'b0;
                    raddr_d   = bus.araddr2;
                    rlen_d    = bus.arlen2;
                    rburst_d  = bus.arburst2;
                    rbeat_d   = 8'd0;
                    rwait_d   = 4'd0;
                    if (RD_WAIT == 0) begin
                        r_state_d  = R_DATA;
                        pres       = 1'b1;
                        pres_addr  = bus.araddr2;
                        pres_burst = bus.arburst2;
                        pres_last  = (bus.arlen2 == 8'd0);
                    end else begin
                        r_state_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (rwait_q == 4'(RD_WAIT - 1)) begin
                    r_state_d = R_DATA;
                    pres      = 1'b1;
                end else begin
                    rwait_d = rwait_q + 4'd1;
                end
            end
            R_DATA: begin
                if (bus.rready2) begin
                    if (rbeat_q == rlen_q) begin
                        r_state_d = R_IDLE;
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        rresp_d   = 2'b00;
                        rdata_d   = 64'd0;
                        arready_d = 1'b1;
                    end else begin
                        rbeat_d   = rbeat_q + 8'd1;
                        raddr_d   = step_addr(raddr_q, rburst_q);
                        pres      = 1'b1;
                        pres_addr = step_addr(raddr_q, rburst_q);
                        pres_last = (rbeat_q + 8'd1 == rlen_q);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        // Memory is read before this edge's write lands, so a same-cycle
        // collision returns the old word.
        if (pres) begin
            rvalid_d = 1'b1;
            rlast_d  = pres_last;
            if (pres_burst[1]) begin
                rresp_d = 2'b10;
                rdata_d = 64'd0;
            end else if (!in_range(pres_addr)) begin
                rresp_d = 2'b11;
                rdata_d = 64'd0;
            end else begin
                rresp_d = 2'b00;
                rdata_d = mem[to_idx(pres_addr)];
            end
        end
    end

    always_comb begin
        w_state_d  = w_state_q;
        waddr_d    = waddr_q;
        wlen_d     = wlen_q;
        wbeat_d    = wbeat_q;
        wburst_d   = wburst_q;
        werr_dec_d = werr_dec_q;
        werr_slv_d = werr_slv_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        mem_we     = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (bus.awvalid2 && awready_q) begin
                    awready_d  = 1'b0;
                    wready_d   = 1'b1;
                    waddr_d    = bus.awaddr2;
                    wlen_d     = bus.awlen2;
                    wburst_d   = bus.awburst2;
                    wbeat_d    = 8'd0;
                    werr_dec_d = 1'b0;
                    werr_slv_d = 1'b0;
                    w_state_d  = W_DATA;
                end
            end
            W_DATA: begin
                if (bus.wvalid2 && wready_q) begin
                    if (wburst_q[1]) begin
                        werr_slv_d = 1'b1;
                    end else if (!in_range(waddr_q)) begin
                        werr_dec_d = 1'b1;
                    end else begin
                        mem_we = 1'b1;
                    end
                    // Beat count, not wlast2, ends the burst; a disagreeing wlast2 is only flagged.
                    if (bus.wlast2 != (wbeat_q == wlen_q)) begin
                        werr_slv_d = 1'b1;
                    end
                    if (wbeat_q == wlen_q) begin
                        w_state_d = W_RESP;
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bresp_d   = werr_dec_d ? 2'b11 : (werr_slv_d ? 2'b10 : 2'b00);
                    end else begin
                        wbeat_d = wbeat_q + 8'd1;
                        waddr_d = step_addr(waddr_q, wburst_q);
                    end
                end
            end
            W_RESP: begin
                if (bus.bready2) begin
                    w_state_d = W_IDLE;
                    bvalid_d  = 1'b0;
                    bresp_d   = 2'b00;
                    awready_d = 1'b1;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst && mem_we) begin
            for (int i = 0; i < 8; i++) begin
                if (bus.wstrb2[i]) begin
                    mem[to_idx(waddr_q)][8*i +: 8] <= bus.wdata2[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state_q  <= R_IDLE;
            raddr_q    <= 32'd0;
            rlen_q     <= 8'd0;
            rbeat_q    <= 8'd0;
            rburst_q   <= 2'b00;
            rwait_q    <= 4'd0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rresp_q    <= 2'b00;
            rdata_q    <= 64'd0;
            w_state_q  <= W_IDLE;
            waddr_q    <= 32'd0;
            wlen_q     <= 8'd0;
            wbeat_q    <= 8'd0;
            wburst_q   <= 2'b00;
            werr_dec_q <= 1'b0;
            werr_slv_q <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
        end else begin
            r_state_q  <= r_state_d;
            raddr_q    <= raddr_d;
            rlen_q     <= rlen_d;
            rbeat_q    <= rbeat_d;
            rburst_q   <= rburst_d;
            rwait_q    <= rwait_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rlast_q    <= rlast_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            w_state_q  <= w_state_d;
            waddr_q    <= waddr_d;
            wlen_q     <= wlen_d;
            wbeat_q    <= wbeat_d;
            wburst_q   <= wburst_d;
            werr_dec_q <= werr_dec_d;
            werr_slv_q <= werr_slv_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
        end
    end

    assign bus.arready2 = arready_q;
    assign bus.rvalid2  = rvalid_q;
    assign bus.rlast2   = rlast_q;
    assign bus.rresp2   = rresp_q;
    assign bus.rdata2   = rdata_q;
    assign bus.awready2 = awready_q;
    assign bus.wready2  = wready_q;
    assign bus.bvalid2  = bvalid_q;
    assign bus.bresp2   = bresp_q;

    // Transfer size is fixed at one doubleword per beat.
    logic unused_ok;
    assign unused_ok = ^bus.arsize2;
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb/tb_axi_sram_slave.sv - self-checking bench for axi_sram_slave
module tb_axi_sram_slave;
    localparam int          RD_WAIT = 2;
    localparam int          DEPTH   = 1024;
    localparam logic [31:0] BASE    = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    axi_sram_if bus();

    axi_sram_slave #(.DEPTH_LOG2(10), .BASE_ADDR(BASE), .RD_WAIT(RD_WAIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] model [DEPTH];
    logic [63:0] wbuf [256];
    logic [7:0]  sbuf [256];
    logic [63:0] rdat [256];
    logic [1:0]  rrsp [256];
    logic [1:0]  last_bresp;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  burst;
        logic [63:0] wdata;
        logic [7:0]  strb;
        logic [1:0]  bresp;
        logic [1:0]  rresp;
        logic [63:0] rdata;
    } vec_t;
    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_in(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'(8 * DEPTH));
    endfunction

    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] burst, input int b);
        return (burst == 2'b01) ? a + 32'(8 * b) : a;
    endfunction

    task automatic check_outputs_zero();
        check("rst_arready", bus.arready2, 0);
        check("rst_rvalid",  bus.rvalid2, 0);
        check("rst_rlast",   bus.rlast2, 0);
        check("rst_rresp",   bus.rresp2, 0);
        check("rst_rdata",   bus.rdata2, 0);
        check("rst_awready", bus.awready2, 0);
        check("rst_wready",  bus.wready2, 0);
        check("rst_bvalid",  bus.bvalid2, 0);
        check("rst_bresp",   bus.bresp2, 0);
    endtask

    task automatic ar_issue(input logic [31:0] addr, input logic [1:0] burst, input int len);
        int n;
        @(negedge clk);
        bus.araddr2 = addr; bus.arburst2 = burst; bus.arlen2 = 8'(len);
        bus.arsize2 = 3'd3; bus.arvalid2 = 1'b1;
        n = 0;
        while (!bus.arready2 && n < 100) begin @(negedge clk); n++; end
        check("ar_timeout", 64'(n >= 100), 0);
        @(negedge clk);
        bus.arvalid2 = 1'b0;
    endtask

    // rmode: 0 rready always high, 1 random, 2 repeating 1,0,0,1
    task automatic axi_read(input logic [31:0] addr, input logic [1:0] burst, input int len, input int rmode);
        int n, b, lat, k;
        bit stalled;
        logic [31:0] ba;
        logic [63:0] ed, pd;
        logic [1:0]  er, pr;
        logic        pl;
        ar_issue(addr, burst, len);
        lat = 0;
        while (!bus.rvalid2 && lat < 50) begin @(negedge clk); lat++; end
        check("r_latency", 64'(lat), 64'(RD_WAIT));
        b = 0; n = 0; k = 0; stalled = 0; pd = '0; pr = '0; pl = 1'b0;
        while (b <= len && n < 3000) begin
            check("r_valid_in_burst", bus.rvalid2, 1);
            if (stalled) begin
                check("r_hold_data", bus.rdata2, pd);
                check("r_hold_resp_last", {bus.rresp2, bus.rlast2}, {pr, pl});
            end
            bus.rready2 = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom_range(1)) :
                          1'((k % 4 == 0) || (k % 4 == 3));
            k++;
            if (bus.rready2) begin
                ba = beat_addr(addr, burst, b);
                if (burst[1])        begin er = 2'b10; ed = 64'd0; end
                else if (!m_in(ba))  begin er = 2'b11; ed = 64'd0; end
                else                 begin er = 2'b00; ed = model[int'((ba - BASE) >> 3)]; end
                check("r_data", bus.rdata2, ed);
                check("r_resp", bus.rresp2, er);
                check("r_last", bus.rlast2, 64'(b == len));
                rdat[b] = bus.rdata2; rrsp[b] = bus.rresp2;
                b++;
                stalled = 0;
            end else begin
                stalled = 1; pd = bus.rdata2; pr = bus.rresp2; pl = bus.rlast2;
            end
            @(negedge clk); n++;
        end
        bus.rready2 = 1'b0;
        check("r_timeout", 64'(n >= 3000), 0);
        check("r_valid_drop", bus.rvalid2, 0);
        check("r_arready_back", bus.arready2, 1);
    endtask

    // wmode: 0 wlast on final beat, 1 wlast on beat 0 only, 2 wlast never
    task automatic axi_write(input logic [31:0] addr, input logic [1:0] burst, input int len,
                             input int wmode, input bit gaps);
        int n, b;
        bit dec, slv;
        logic [31:0] ba;
        logic [1:0]  exp;
        @(negedge clk);
        bus.awaddr2 = addr; bus.awburst2 = burst; bus.awlen2 = 8'(len); bus.awvalid2 = 1'b1;
        n = 0;
        while (!bus.awready2 && n < 100) begin @(negedge clk); n++; end
        check("aw_timeout", 64'(n >= 100), 0);
        @(negedge clk);
        bus.awvalid2 = 1'b0;
        b = 0; n = 0; dec = 0; slv = 0;
        while (b <= len && n < 3000) begin
            if (gaps && $urandom_range(3) == 0) begin
                bus.wvalid2 = 1'b0;
            end else begin
                bus.wvalid2 = 1'b1; bus.wdata2 = wbuf[b]; bus.wstrb2 = sbuf[b];
                bus.wlast2  = (wmode == 0) ? (b == len) : (wmode == 1) ? (b == 0) : 1'b0;
                if (bus.wready2) begin
                    ba = beat_addr(addr, burst, b);
                    if (burst[1]) slv = 1;
                    else if (!m_in(ba)) dec = 1;
                    else begin
                        for (int i = 0; i < 8; i++)
                            if (sbuf[b][i]) model[int'((ba - BASE) >> 3)][8*i +: 8] = wbuf[b][8*i +: 8];
                    end
                    if (bus.wlast2 != (b == len)) slv = 1;
                    b++;
                end
            end
            @(negedge clk); n++;
        end
        bus.wvalid2 = 1'b0; bus.wlast2 = 1'b0;
        check("w_timeout", 64'(n >= 3000), 0);
        exp = dec ? 2'b11 : (slv ? 2'b10 : 2'b00);
        n = 0;
        bus.bready2 = gaps ? 1'($urandom_range(1)) : 1'b1;
        while (!(bus.bvalid2 && bus.bready2) && n < 100) begin
            @(negedge clk); n++;
            bus.bready2 = gaps ? 1'($urandom_range(1)) : 1'b1;
        end
        check("b_timeout", 64'(n >= 100), 0);
        check("w_ready_in_resp", bus.wready2, 0);
        check("b_resp", bus.bresp2, exp);
        last_bresp = bus.bresp2;
        @(negedge clk);
        bus.bready2 = 1'b0;
        check("b_valid_drop", bus.bvalid2, 0);
        check("b_awready_back", bus.awready2, 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, len, idx;
        logic [1:0]  burst;
        logic [31:0] a;

        bus.araddr2 = '0; bus.arvalid2 = 0; bus.arburst2 = '0; bus.arlen2 = '0; bus.arsize2 = '0;
        bus.rready2 = 0; bus.awaddr2 = '0; bus.awvalid2 = 0; bus.awburst2 = '0; bus.awlen2 = '0;
        bus.wdata2 = '0; bus.wlast2 = 0; bus.wstrb2 = '0; bus.wvalid2 = 0; bus.bready2 = 0;

        vecs[0] = '{32'h8000_0008, 2'b01, 64'h0,                    8'hFF, 2'b00, 2'b00, 64'h0};
        vecs[1] = '{32'h8000_0008, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 2'b00, 2'b00, 64'h0000_0000_FFFF_FFFF};
        vecs[2] = '{32'h8000_000C, 2'b00, 64'h1122_3344_5566_7788, 8'h80, 2'b00, 2'b00, 64'h1100_0000_FFFF_FFFF};
        vecs[3] = '{32'h1000_0000, 2'b01, 64'h1234,                 8'hFF, 2'b11, 2'b11, 64'h0};
        vecs[4] = '{32'h8000_0000, 2'b10, 64'hDEAD_BEEF,            8'hFF, 2'b10, 2'b10, 64'h0};
        vecs[5] = '{32'h8000_1FF8, 2'b01, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF, 2'b00, 2'b00, 64'hA5A5_5A5A_0F0F_F0F0};
        vecs[6] = '{32'h8000_2000, 2'b01, 64'h1,                    8'hFF, 2'b11, 2'b11, 64'h0};
        vecs[7] = '{32'h7FFF_FFF8, 2'b00, 64'h1,                    8'hFF, 2'b11, 2'b11, 64'h0};
        vecs[8] = '{32'h8000_0010, 2'b11, 64'h77,                   8'hFF, 2'b10, 2'b10, 64'h0};

        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero();
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_arready", bus.arready2, 1);
        check("post_rst_awready", bus.awready2, 1);

        // Clear the whole RAM so the model starts fully known
        for (int i = 0; i < DEPTH; i++) model[i] = 64'd0;
        for (int i = 0; i < 256; i++) begin wbuf[i] = 64'd0; sbuf[i] = 8'hFF; end
        for (int c = 0; c < 4; c++) axi_write(BASE + 32'(c * 2048), 2'b01, 255, 0, 0);

        // Single read of a preloaded word
        wbuf[0] = 64'h1122_3344_5566_7788;
        axi_write(BASE, 2'b01, 0, 0, 0);
        axi_read(BASE, 2'b01, 0, 0);
        check("single_read_data", rdat[0], 64'h1122_3344_5566_7788);

        // INCR burst write then read-back
        for (int i = 0; i < 4; i++) begin wbuf[i] = 64'hD0D0_0000_0000_0000 + 64'(i); sbuf[i] = 8'hFF; end
        axi_write(32'h8000_0010, 2'b01, 3, 0, 0);
        check("incr_bresp", last_bresp, 2'b00);
        axi_read(32'h8000_0010, 2'b01, 3, 0);
        for (int i = 0; i < 4; i++) check("incr_readback", rdat[i], 64'hD0D0_0000_0000_0000 + 64'(i));

        // Table-driven single-beat vectors
        for (int v = 0; v < 9; v++) begin
            wbuf[0] = vecs[v].wdata; sbuf[0] = vecs[v].strb;
            axi_write(vecs[v].addr, vecs[v].burst, 0, 0, 0);
            check("tbl_bresp", last_bresp, vecs[v].bresp);
            axi_read(vecs[v].addr, vecs[v].burst, 0, 1);
            check("tbl_rresp", rrsp[0], vecs[v].rresp);
            check("tbl_rdata", rdat[0], vecs[v].rdata);
        end

        // Backpressure on a len7 read
        for (int i = 0; i < 8; i++) begin wbuf[i] = {$urandom, $urandom}; sbuf[i] = 8'hFF; end
        axi_write(BASE + 32'h100, 2'b01, 7, 0, 0);
        axi_read(BASE + 32'h100, 2'b01, 7, 2);

        // wlast errors
        axi_write(BASE + 32'h200, 2'b01, 1, 1, 0);
        check("early_wlast_bresp", last_bresp, 2'b10);
        axi_write(BASE + 32'h200, 2'b01, 1, 2, 0);
        check("missing_wlast_bresp", last_bresp, 2'b10);
        axi_read(BASE + 32'h200, 2'b01, 1, 0);

        // Randomised bursts against the model
        for (int t = 0; t < 25; t++) begin
            burst = ($urandom_range(9) == 0) ? 2'b11 : ($urandom_range(1) ? 2'b01 : 2'b00);
            idx   = $urandom_range(1) ? int'($urandom_range(1023)) : 1016 + int'($urandom_range(7));
            len   = ($urandom_range(4) == 0) ? int'($urandom_range(20)) : int'($urandom_range(7));
            a     = BASE + 32'(idx * 8) + 32'($urandom_range(7));
            for (int i = 0; i <= len; i++) begin wbuf[i] = {$urandom, $urandom}; sbuf[i] = 8'($urandom_range(255)); end
            axi_write(a, burst, len, 0, 1);
            axi_read(a, burst, len, 1);
            axi_read(BASE + 32'(8 * $urandom_range(1023)), 2'($urandom_range(1)), int'($urandom_range(5)), 1);
        end

        // Reset in the middle of a len7 read
        ar_issue(BASE, 2'b01, 7);
        n = 0;
        while (!bus.rvalid2 && n < 50) begin @(negedge clk); n++; end
        check("mid_rst_wait", 64'(n >= 50), 0);
        bus.rready2 = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_rst_beat2", bus.rdata2, model[2]);
        bus.rready2 = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check_outputs_zero();
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_arready", bus.arready2, 1);
        axi_read(BASE, 2'b01, 3, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
